spi_frame_bank: RTL and testbench

Parametrised SPI-slave register bank for the stepper/IO CPLD: the next generation of the SPI front end that feeds the stepgen channels. It supports NCH channels, configurable field widths, a coherent position/input snapshot at frame start, and shadowed writes. Received fields take effect only when a complete, well-formed frame ends, so an aborted or corrupted transfer leaves the live outputs untouched. It sits between the SPI pins and the stepgen, watchdog and digital-output logic.

---
 rtl/spi_frame_bank.sv | 241 ++++++++++++++++++++++++
 tb/tb_spi_frame_bank.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_bank.sv
// spi_frame_bank -- SPI-slave (mode 0) register bank feeding the stepgen,
// watchdog and digital-output logic of the stepper/IO CPLD.
//
// A frame is L = 4*(NCH+2) bytes. Received fields land in shadow registers
// and reach the live outputs only when SSEL rises on a complete, well-formed
// frame. pos/din are snapshotted at SSEL fall and shifted out on MISO.
//
// Optional feature: define SPI_FRAME_CKSUM_EN to also require the XOR of all
// L received bytes to equal 8'hA5 before a frame is accepted.
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   SCK, SSEL, MOSI    SPI pins (asynchronous to clk), SSEL active low
//   MISO               SPI data out, MSB first
//   pos [NCH*PW]       stepgen positions, channel k at [k*PW +: PW]
//   din [IW]           digital inputs
//   vel [NCH*VW]       live velocities, channel k at [k*VW +: VW]
//   dout [OW]          live digital outputs
//   dirtime, steptime  live stepgen timing [TW]
//   spol, tap          step polarity, stepgen tap select
//   wdt_kick           one-clk watchdog enable request
//   frame_ok/err       one-clk pulse per accepted / rejected frame
module spi_frame_bank #(
  parameter int NCH = 4,
  parameter int VW  = 12,
  parameter int PW  = 21,
  parameter int IW  = 16,
  parameter int OW  = 14,
  parameter int TW  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SCK,
  input  logic              SSEL,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [NCH*PW-1:0] pos,
  input  logic [IW-1:0]     din,
  output logic [NCH*VW-1:0] vel,
  output logic [OW-1:0]     dout,
  output logic [TW-1:0]     dirtime,
  output logic [TW-1:0]     steptime,
  output logic              spol,
  output logic [1:0]        tap,
  output logic              wdt_kick,
  output logic              frame_ok,
  output logic              frame_err
);

  localparam int         L      = 4 * (NCH + 2);
  localparam logic [7:0] B_LEN  = 8'(L);
  localparam logic [7:0] B_DOUT = 8'(4 * NCH + 1);
  localparam logic [7:0] B_TIME = 8'(4 * NCH + 2);
  localparam logic [7:0] B_CTL  = 8'(4 * NCH + 3);
  localparam logic [5:0] W_DIN  = 6'(NCH);
  localparam logic [5:0] W_STAT = 6'(NCH + 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic sck_p0, sck_p1, sck_p2;
  logic ssel_p0, ssel_p1, ssel_p2;
  logic mosi_p0, mosi_p1;
  logic sck_rise, ssel_fall, ssel_rise;

  logic       active;
  logic [2:0] bit_cnt;
  logic [7:0] byte_cnt;
  logic [6:0] rx_sr;
  logic [7:0] lo_byte;
  logic [7:0] rx_byte;
  logic       byte_done;

  logic [VW-1:0] vel_sh [NCH];
  logic [VW-1:0] vel_live [NCH];
  logic [OW-1:0] dout_sh;
  logic [TW-1:0] dir_sh, stp_sh;
  logic          spol_sh, wd_sh;
  logic [1:0]    tap_sh;

  logic [7:0]        commit_cnt, err_cnt;
  logic [NCH*PW-1:0] pos_snap;
  logic [IW-1:0]     din_snap;
  logic [31:0]       tx_word;
  logic [7:0]        tx_byte;
  logic              len_ok, cksum_ok, accept, reject;

  // Stage p0/p1: two-flop synchronisers; p2: edge-detect reference.
  // SSEL stages reset low so a reset released mid-frame never sees a fall;
  // only a later rise (ignored while inactive) and then a genuine fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_p0  <= 1'b0; sck_p1  <= 1'b0; sck_p2  <= 1'b0;
      ssel_p0 <= 1'b0; ssel_p1 <= 1'b0; ssel_p2 <= 1'b0;
      mosi_p0 <= 1'b0; mosi_p1 <= 1'b0;
    end else begin
      sck_p0  <= SCK;  sck_p1  <= sck_p0;  sck_p2  <= sck_p1;
      ssel_p0 <= SSEL; ssel_p1 <= ssel_p0; ssel_p2 <= ssel_p1;
      mosi_p0 <= MOSI; mosi_p1 <= mosi_p0;
    end
  end

  assign sck_rise  = sck_p1 & ~sck_p2;
  assign ssel_fall = ~ssel_p1 & ssel_p2;
  assign ssel_rise = ssel_p1 & ~ssel_p2;

  // Byte assembly: only complete bytes are counted (saturating at 255).
  assign rx_byte   = {rx_sr, mosi_p1};
  assign byte_done = active & sck_rise & ~ssel_fall & ~ssel_rise & (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      rx_sr    <= '0;
      lo_byte  <= '0;
    end else if (ssel_fall) begin
      active   <= 1'b1;
      bit_cnt  <= '0;
      byte_cnt <= '0;
    end else if (ssel_rise) begin
      active   <= 1'b0;
    end else if (active && sck_rise) begin
      rx_sr   <= rx_byte[6:0];
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) begin
        lo_byte  <= rx_byte;
        byte_cnt <= sat_inc8(byte_cnt);
      end
    end
  end

`ifdef SPI_FRAME_CKSUM_EN
  logic [7:0] cksum;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cksum <= '0;
    else if (ssel_fall) cksum <= '0;
    else if (byte_done) cksum <= cksum ^ rx_byte;
  end
  assign cksum_ok = (cksum == 8'hA5);
`else
  assign cksum_ok = 1'b1;
`endif

  // Shadow stage: each field is written as its last byte completes; the
  // previous byte (lo_byte) supplies the low half of 16-bit fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) vel_sh[k] <= '0;
      dout_sh <= '0;
      dir_sh  <= '0;
      stp_sh  <= '0;
      spol_sh <= 1'b0;
      wd_sh   <= 1'b0;
      tap_sh  <= '0;
    end else if (byte_done) begin
      for (int k = 0; k < NCH; k++)
        if (byte_cnt == 8'(4 * k + 1)) vel_sh[k] <= VW'({rx_byte, lo_byte});
      if (byte_cnt == B_DOUT) dout_sh <= OW'({rx_byte, lo_byte});
      if (byte_cnt == B_TIME) begin
        spol_sh <= rx_byte[7];
        dir_sh  <= TW'(rx_byte);
      end
      if (byte_cnt == B_CTL) begin
        tap_sh <= rx_byte[7:6];
        wd_sh  <= rx_byte[5];
        stp_sh <= TW'(rx_byte);
      end
    end
  end

  // Commit stage: a partial trailing byte leaves bit_cnt non-zero and fails
  // the length test.
  assign len_ok = (byte_cnt == B_LEN) && (bit_cnt == 3'd0);
  assign accept = active && ssel_rise && len_ok && cksum_ok;
  assign reject = active && ssel_rise && !(len_ok && cksum_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) vel_live[k] <= '0;
      dout       <= '0;
      dirtime    <= '0;
      steptime   <= '0;
      spol       <= 1'b0;
      tap        <= '0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      wdt_kick   <= 1'b0;
      commit_cnt <= '0;
      err_cnt    <= '0;
    end else begin
      frame_ok  <= accept;
      frame_err <= reject;
      wdt_kick  <= accept & wd_sh;
      if (accept) begin
        for (int k = 0; k < NCH; k++) vel_live[k] <= vel_sh[k];
        dout       <= dout_sh;
        dirtime    <= dir_sh;
        steptime   <= stp_sh;
        spol       <= spol_sh;
        tap        <= tap_sh;
        commit_cnt <= commit_cnt + 8'd1;
      end
      if (reject) err_cnt <= sat_inc8(err_cnt);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_vel
    assign vel[g*VW +: VW] = vel_live[g];
  end

  // Snapshot stage: pos/din frozen at SSEL fall so MISO reads one instant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_snap <= '0;
      din_snap <= '0;
    end else if (ssel_fall) begin
      pos_snap <= pos;
      din_snap <= din;
    end
  end

  // Transmit stage: byte/bit counters select the outgoing bit directly, so
  // MISO moves one clk after the receive counters advance on SCK rise.
  always_comb begin
    tx_word = '0;
    for (int k = 0; k < NCH; k++)
      if (byte_cnt[7:2] == 6'(k)) tx_word = 32'(pos_snap[k*PW +: PW]);
    if (byte_cnt[7:2] == W_DIN)  tx_word = 32'(din_snap);
    if (byte_cnt[7:2] == W_STAT) tx_word = {16'h0000, err_cnt, commit_cnt};
    tx_byte = tx_word[{byte_cnt[1:0], 3'b000} +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) MISO <= 1'b0;
    else        MISO <= active ? tx_byte[~bit_cnt] : 1'b0;
  end

endmodule

// File: tb/tb_spi_frame_bank.sv
module tb_spi_frame_bank;
  localparam int NCH  = 4;
  localparam int VW   = 12;
  localparam int PW   = 21;
  localparam int IW   = 16;
  localparam int OW   = 14;
  localparam int TW   = 4;
  localparam int L    = 4 * (NCH + 2);
  localparam int HALF = 4;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              SCK   = 1'b0;
  logic              SSEL  = 1'b1;
  logic              MOSI  = 1'b0;
  logic              MISO;
  logic [NCH*PW-1:0] pos   = '0;
  logic [IW-1:0]     din   = '0;
  logic [NCH*VW-1:0] vel;
  logic [OW-1:0]     dout;
  logic [TW-1:0]     dirtime, steptime;
  logic              spol;
  logic [1:0]        tap;
  logic              wdt_kick, frame_ok, frame_err;

  spi_frame_bank #(.NCH(NCH), .VW(VW), .PW(PW), .IW(IW), .OW(OW), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .SCK(SCK), .SSEL(SSEL), .MOSI(MOSI), .MISO(MISO),
    .pos(pos), .din(din), .vel(vel), .dout(dout), .dirtime(dirtime),
    .steptime(steptime), .spol(spol), .tap(tap), .wdt_kick(wdt_kick),
    .frame_ok(frame_ok), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: live register file, counters and driven inputs.
  int unsigned m_vel[NCH];
  int unsigned m_pos[NCH];
  int unsigned m_dout, m_dir, m_stp, m_spol, m_tap, m_commit, m_err, m_din;
  logic [7:0]  mb[64];
  logic [7:0]  rb[64];
  logic [7:0]  rx_cur;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic int unsigned mask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pos(input int k, input int unsigned v);
    m_pos[k] = v & mask(PW);
    pos[k*PW +: PW] = PW'(m_pos[k]);
  endtask

  task automatic set_din(input int unsigned v);
    m_din = v & mask(IW);
    din = IW'(m_din);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) m_vel[k] = 0;
    m_dout = 0; m_dir = 0; m_stp = 0; m_spol = 0; m_tap = 0;
    m_commit = 0; m_err = 0;
  endtask

  task automatic check_live(input string tag);
    for (int k = 0; k < NCH; k++)
      chk($sformatf("%s vel%0d", tag, k), 32'(vel[k*VW +: VW]), m_vel[k]);
    chk({tag, " dout"}, 32'(dout), m_dout);
    chk({tag, " dirtime"}, 32'(dirtime), m_dir);
    chk({tag, " steptime"}, 32'(steptime), m_stp);
    chk({tag, " spol"}, 32'(spol), m_spol);
    chk({tag, " tap"}, 32'(tap), m_tap);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) mb[i] = 8'($urandom);
  endtask

  task automatic fix_ck();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < L - 1; i++) x = x ^ mb[i];
    mb[L-1] = x ^ 8'hA5;
  endtask

  // Mode 0: MOSI set while SCK low, MISO sampled just before SCK rises.
  task automatic spi_bits(input logic [7:0] tx, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      MOSI = tx[i];
      clks(HALF);
      rx_cur[i] = MISO;
      SCK = 1'b1;
      clks(HALF);
      SCK = 1'b0;
    end
  endtask

  task automatic run_frame(input string tag, input int nb, input int xbits,
                           input int chg_at, input int rst_at);
    logic [31:0] wv[NCH+2];
    logic [7:0]  x, e;
    bit          was_rst, accept, ck_ok;
    int          okn, errn, kickn;
    was_rst = 0; okn = 0; errn = 0; kickn = 0;
    for (int k = 0; k < NCH; k++) wv[k] = m_pos[k];
    wv[NCH]   = m_din;
    wv[NCH+1] = {16'h0000, 8'(m_err), 8'(m_commit)};
    SSEL = 1'b0;
    clks(6);
    for (int b = 0; b < nb; b++) begin
      if (b == chg_at) set_pos(0, 32'h200);
      rx_cur = 8'h00;
      if (b == rst_at) begin
        spi_bits(mb[b], 7, 5);
        rst_n = 1'b0;
        clks(2);
        model_reset();
        was_rst = 1;
        check_live({tag, " in-reset"});
        chk({tag, " in-reset miso"}, 32'(MISO), 32'd0);
        chk({tag, " in-reset pulses"}, {29'd0, frame_ok, frame_err, wdt_kick}, 32'd0);
        rst_n = 1'b1;
        clks(2);
        spi_bits(mb[b], 4, 0);
      end else begin
        spi_bits(mb[b], 7, 0);
      end
      rb[b] = rx_cur;
      if (!was_rst) begin
        if (b < L) e = 8'(wv[b/4] >> (8 * (b % 4)));
        else       e = 8'h00;
        chk($sformatf("%s miso byte %0d", tag, b), 32'(rx_cur), 32'(e));
      end
    end
    if (xbits > 0) spi_bits(mb[nb], 7, 8 - xbits);
    clks(3);
    SSEL = 1'b1;

    x = 8'h00;
    for (int i = 0; i < L; i++) x = x ^ mb[i];
`ifdef SPI_FRAME_CKSUM_EN
    ck_ok = (x == 8'hA5);
`else
    ck_ok = 1'b1;
`endif
    accept = !was_rst && (nb == L) && (xbits == 0) && ck_ok;
    if (accept) begin
      for (int k = 0; k < NCH; k++)
        m_vel[k] = (int'(mb[4*k+1]) * 256 + int'(mb[4*k])) & mask(VW);
      m_dout   = (int'(mb[4*NCH+1]) * 256 + int'(mb[4*NCH])) & mask(OW);
      m_spol   = int'(mb[4*NCH+2]) / 128;
      m_dir    = int'(mb[4*NCH+2]) & mask(TW);
      m_tap    = int'(mb[4*NCH+3]) / 64;
      m_stp    = int'(mb[4*NCH+3]) & mask(TW);
      m_commit = (m_commit + 1) % 256;
    end else if (!was_rst) begin
      m_err = (m_err < 255) ? m_err + 1 : 255;
    end

    for (int c = 1; c <= 10; c++) begin
      clks(1);
      okn   += int'(frame_ok);
      errn  += int'(frame_err);
      kickn += int'(wdt_kick);
      if (c == 4) check_live(tag);
    end
    chk({tag, " frame_ok pulses"}, okn, 32'(accept));
    chk({tag, " frame_err pulses"}, errn, 32'(!was_rst && !accept));
    chk({tag, " wdt_kick pulses"}, kickn, 32'(accept && mb[4*NCH+3][5]));
    clks(8);
  endtask

  initial begin
    for (int k = 0; k < NCH; k++) set_pos(k, $urandom);
    set_din($urandom);
    model_reset();
    clks(3);
    check_live("reset");
    chk("reset miso", 32'(MISO), 32'd0);
    chk("reset pulses", {29'd0, frame_ok, frame_err, wdt_kick}, 32'd0);
    rst_n = 1'b1;
    clks(4);

    // Directed write: vel0=0x123, dout=0x2A5A, watchdog enable set.
    fill_rand();
    mb[0] = 8'h23; mb[1] = 8'h01;
    mb[4*NCH] = 8'h5A; mb[4*NCH+1] = 8'h2A;
    mb[4*NCH+3] = 8'h63;
    fix_ck();
    run_frame("write1", L, 0, -1, -1);
    chk("write1 vel0 value", 32'(vel[VW-1:0]), 32'h123);
    chk("write1 dout value", 32'(dout), 32'h2A5A);

    fill_rand(); fix_ck();
    run_frame("after-write1", L, 0, -1, -1);
    chk("commit count read", 32'(rb[4*NCH+4]), 32'd1);

    fill_rand();
    run_frame("abort10", 10, 0, -1, -1);
    fill_rand(); fix_ck();
    run_frame("after-abort", L, 0, -1, -1);
    chk("err count read", 32'(rb[4*NCH+5]), 32'd1);

    set_pos(0, 32'h100);
    fill_rand(); fix_ck();
    run_frame("snapshot", L, 0, 1, -1);
    chk("snapshot pos0 bytes", 32'({rb[2], rb[1], rb[0]}), 32'h000100);

    fill_rand(); fix_ck();
    mb[8] = mb[8] ^ 8'h01;
    run_frame("bitflip", L, 0, -1, -1);

    for (int it = 0; it < 12; it++) begin
      int r, nb, xb;
      for (int k = 0; k < NCH; k++) set_pos(k, $urandom);
      set_din($urandom);
      fill_rand();
      if ($urandom_range(0, 3) != 0) fix_ck();
      r = $urandom_range(0, 3);
      nb = L; xb = 0;
      if (r == 2) nb = $urandom_range(0, L + 3);
      if (r == 3) xb = $urandom_range(1, 7);
      run_frame($sformatf("rand%0d", it), nb, xb, -1, -1);
    end

    for (int i = 0; i < 300; i++) begin
      fill_rand();
      run_frame("short", 1, 0, -1, -1);
    end
    fill_rand(); fix_ck();
    run_frame("post-sat", L, 0, -1, -1);
    chk("err count saturated", 32'(rb[4*NCH+5]), 32'hFF);

    fill_rand(); fix_ck();
    run_frame("rst-mid", L, 0, -1, 5);
    chk("rst-mid vel all zero", 32'(vel), 32'd0);
    chk("rst-mid dout zero", 32'(dout), 32'd0);
    fill_rand(); fix_ck();
    run_frame("post-rst", L, 0, -1, -1);
    fill_rand(); fix_ck();
    run_frame("post-rst2", L, 0, -1, -1);
    chk("post-rst commit count", 32'(rb[4*NCH+4]), 32'd1);
    chk("post-rst err count", 32'(rb[4*NCH+5]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
